subseq_scan_ctrl: RTL and testbench

SUBSEQ_SCAN_CTRL -- requirements
Module: subseq_scan_ctrl

---
 rtl/subseq_scan_if.sv | 27 ++
 rtl/subseq_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_subseq_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/subseq_scan_if.sv
// Stream-side bundle for subseq_scan_ctrl: word input handshake and
// per-frame match-count output handshake.
//   in_valid/in_data/in_last/in_ready : word input, accepted when valid & ready
//   out_valid/out_count/out_ready     : frame match count, held until out_ready
// master = producer/consumer side (bench), slave = the scanner.
interface subseq_scan_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/subseq_scan_ctrl.sv
// Serial subsequence scanner. Accepts parallel words, scans them MSB first
// one bit per cycle, counts (overlapping) occurrences of a programmable
// 1..8 bit pattern across all words of a frame, and reports the count once
// the frame's last word has been scanned.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cfg_we_i              : pattern/length write, honoured only while idle
//   cfg_pattern_i[7:0]    : pattern, bit 0 = most recent stream bit
//   cfg_len_i[3:0]        : pattern length (0 -> 1, >8 -> 8)
//   bus                   : word input / count output handshakes
//   match_pulse_o         : one-cycle strobe per match
//   busy_o                : frame open or FSM not idle
//
// state  | meaning
// IDLE   | waiting for a word (in_ready = 1)
// SHIFT  | consuming captured word, one bit per cycle
// REPORT | frame done, count presented until out_ready
module subseq_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_we_i,
  input  logic [7:0] cfg_pattern_i,
  input  logic [3:0] cfg_len_i,
  subseq_scan_if.slave bus,
  output logic       match_pulse_o,
  output logic       busy_o
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        hist_q, hist_d;
  logic [3:0]        seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              active_q, active_d;
  logic [7:0]        pat_q, pat_d;
  logic [3:0]        len_q, len_d;

  logic [3:0] eff_len;
  logic [7:0] len_mask;
  logic [7:0] hist_shift;
  logic [3:0] seen_inc;
  logic       hit;

  assign busy_o        = active_q || (state_q != IDLE);
  assign match_pulse_o = pulse_q;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == REPORT);
  assign bus.out_count = cnt_q;

  always_comb begin
    if (len_q == 4'd0)      eff_len = 4'd1;
    else if (len_q > 4'd8)  eff_len = 4'd8;
    else                    eff_len = len_q;
  end

  assign len_mask   = 8'hFF >> (4'd8 - eff_len);
  assign hist_shift = {hist_q[6:0], word_q[idx_q]};
  // bits-seen only needs to reach 8 to qualify any legal length
  assign seen_inc   = (seen_q == 4'd8) ? 4'd8 : seen_q + 4'd1;
  assign hit        = (((hist_shift ^ pat_q) & len_mask) == 8'h00) && (seen_inc >= eff_len);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    last_d   = last_q;
    idx_d    = idx_q;
    hist_d   = hist_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    active_d = active_q;
    pat_d    = pat_q;
    len_d    = len_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d   = bus.in_data;
          last_d   = bus.in_last;
          idx_d    = IDX_W'(WORD_W - 1);
          active_d = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        hist_d = hist_shift;
        seen_d = seen_inc;
        if (hit) begin
          pulse_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == '0) state_d = last_q ? REPORT : IDLE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      REPORT: begin
        if (bus.out_ready) begin
          cnt_d    = '0;
          hist_d   = 8'h00;
          seen_d   = 4'd0;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_we_i && !busy_o) begin
      pat_d = cfg_pattern_i;
      len_d = cfg_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      word_q   <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      hist_q   <= 8'h00;
      seen_q   <= 4'd0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      active_q <= 1'b0;
      pat_q    <= 8'b0000_1001;
      len_q    <= 4'd4;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      hist_q   <= hist_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      active_q <= active_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
    end
  end
endmodule

// File: tb/tb_subseq_scan_ctrl.sv
// Bench for subseq_scan_ctrl: two instances (CNT_W 8 and 4) share one
// stimulus stream; a bit-level reference model computes each frame's
// expected count when its last word is driven, and the count is checked
// when the frame is reported.
module tb_subseq_scan_ctrl;
  localparam int WORD_W = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       mp_a, busy_a, mp_b, busy_b;

  always #5 clk = ~clk;

  subseq_scan_if #(.WORD_W(WORD_W), .CNT_W(8)) bus_a ();
  subseq_scan_if #(.WORD_W(WORD_W), .CNT_W(4)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_last   = bus_a.in_last;
  assign bus_b.out_ready = bus_a.out_ready;

  subseq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .bus(bus_a.slave), .match_pulse_o(mp_a), .busy_o(busy_a)
  );

  subseq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .bus(bus_b.slave), .match_pulse_o(mp_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int pulse_cnt = 0;
  int first_pulse_cyc = 0;

  logic [7:0] m_pat;
  int         m_len;
  bit         frame_open;
  bit         frame_bits[$];
  int         exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mp_a) begin
      if (pulse_cnt == 0) first_pulse_cyc = cyc;
      pulse_cnt++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sliding-window reference: bits in arrival order, pattern bit 0 = newest
  function automatic int model_count();
    int l;
    int c;
    bit ok;
    l = (m_len == 0) ? 1 : ((m_len > 8) ? 8 : m_len);
    c = 0;
    for (int i = l - 1; i < frame_bits.size(); i++) begin
      ok = 1'b1;
      for (int k = 0; k < l; k++)
        if (frame_bits[i-k] != m_pat[k]) ok = 1'b0;
      if (ok) c++;
    end
    return c;
  endfunction

  task automatic send_word(input logic [15:0] d, input bit last);
    int n;
    int v;
    n = 0;
    v = 0;
    @(negedge clk);
    while (!bus_a.in_ready && n < 200) begin
      if (bus_a.out_valid) v++;
      @(negedge clk);
      n++;
    end
    chk_eq("in_ready_wait", bus_a.in_ready, 1);
    chk_eq("valid_while_wait", v, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    last_acc_cyc = cyc;
    for (int i = 15; i >= 0; i--) frame_bits.push_back(d[i]);
    frame_open = 1'b1;
    if (last) begin
      exp_q.push_back(model_count());
      frame_bits.delete();
    end
  endtask

  task automatic collect(input int hold, input bit chk_lat);
    int n;
    int e;
    n = 0;
    while (!bus_a.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("out_valid_wait", bus_a.out_valid, 1);
    if (chk_lat) chk_eq("latency", cyc - last_acc_cyc, WORD_W);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    chk_eq("count_a", bus_a.out_count, e);
    chk_eq("count_b", bus_b.out_count, (e > 15) ? 15 : e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk_eq("hold_valid", bus_a.out_valid, 1);
      chk_eq("hold_count", bus_a.out_count, e);
      chk_eq("hold_in_ready", bus_a.in_ready, 0);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    frame_open = 1'b0;
    chk_eq("post_in_ready", bus_a.in_ready, 1);
    chk_eq("post_out_valid", bus_a.out_valid, 0);
    chk_eq("post_busy", busy_a, 0);
    chk_eq("post_count", bus_a.out_count, 0);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!frame_open) begin
      m_pat = pat;
      m_len = int'(len);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    frame_bits.delete();
    frame_open = 1'b0;
    m_pat = 8'b0000_1001;
    m_len = 4;
  endtask

  initial begin
    int nw;
    rst             = 1'b1;
    cfg_we          = 1'b0;
    cfg_pattern     = 8'h00;
    cfg_len         = 4'd0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.in_last   = 1'b0;
    bus_a.out_ready = 1'b0;
    m_pat           = 8'b0000_1001;
    m_len           = 4;
    frame_open      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk_eq("rst_in_ready", bus_a.in_ready, 1);
    chk_eq("rst_out_valid", bus_a.out_valid, 0);
    chk_eq("rst_busy", busy_a, 0);
    chk_eq("rst_pulse", mp_a, 0);
    chk_eq("rst_count", bus_a.out_count, 0);

    // default 1001/4, overlapping matches
    pulse_cnt = 0;
    send_word(16'h9200, 1'b1);
    collect(0, 1'b1);
    chk_eq("pulses_9200", pulse_cnt, 2);

    // match spanning a word boundary
    send_word(16'h0001, 1'b0);
    send_word(16'h2000, 1'b1);
    collect(0, 1'b0);

    // pattern 11 len 2 over all ones
    do_cfg(8'b0000_0011, 4'd2);
    pulse_cnt = 0;
    send_word(16'hFFFF, 1'b1);
    collect(0, 1'b0);
    chk_eq("first_pulse_ofs", first_pulse_cyc - last_acc_cyc, 2);
    chk_eq("pulses_ffff", pulse_cnt, 15);

    // report held off by out_ready
    send_word(16'hFFFF, 1'b1);
    collect(5, 1'b0);

    // saturation of the narrow counter
    send_word(16'hFFFF, 1'b0);
    send_word(16'hFFFF, 1'b1);
    collect(0, 1'b0);

    // cfg write while busy is ignored
    do_cfg(8'b0000_1001, 4'd4);
    send_word(16'h9200, 1'b1);
    do_cfg(8'b0000_0011, 4'd2);
    collect(0, 1'b0);

    // reset mid-SHIFT discards the frame and restores defaults
    do_cfg(8'b0000_0011, 4'd2);
    send_word(16'hFFFF, 1'b1);
    repeat (5) @(negedge clk);
    do_reset();
    chk_eq("mid_rst_in_ready", bus_a.in_ready, 1);
    chk_eq("mid_rst_out_valid", bus_a.out_valid, 0);
    chk_eq("mid_rst_count", bus_a.out_count, 0);
    chk_eq("mid_rst_busy", busy_a, 0);
    pulse_cnt = 0;
    send_word(16'h9200, 1'b1);
    collect(0, 1'b0);
    chk_eq("pulses_after_rst", pulse_cnt, 2);

    // random frames, including out-of-range lengths
    for (int f = 0; f < 5; f++) begin
      do_cfg(8'($urandom), 4'($urandom_range(0, 15)));
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        send_word(16'($urandom), (w == nw - 1));
      collect($urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
